// File: rtl/sim_ctrl_pkg.sv
// sim_ctrl_pkg: shared types and constants for the simulation-control monitor.
//   state_e          - top-level FSM states (run / pass / fail)
//   FC_*             - fail_code encodings reported on the fail_code output
//   PASS_W*/FAIL_W*  - mailbox magic words that terminate a test
//   is_pass_word/is_fail_word - magic-word decoders
`timescale 1ns/1ps
package sim_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StPass = 2'd1,
    StFail = 2'd2
  } state_e;

  localparam logic [1:0] FC_NONE   = 2'd0;
  localparam logic [1:0] FC_SW     = 2'd1;
  localparam logic [1:0] FC_WDOG   = 2'd2;
  localparam logic [1:0] FC_BUDGET = 2'd3;

  localparam logic [31:0] PASS_W0 = 32'h0000_0FFF;
  localparam logic [31:0] PASS_W1 = 32'hFFFF_0000;
  localparam logic [31:0] FAIL_W0 = 32'h0000_0EEE;
  localparam logic [31:0] FAIL_W1 = 32'hEEEE_0000;

  function automatic logic is_pass_word(input logic [31:0] w);
    return (w == PASS_W0) || (w == PASS_W1);
  endfunction

  function automatic logic is_fail_word(input logic [31:0] w);
    return (w == FAIL_W0) || (w == FAIL_W1);
  endfunction

endpackage

// File: rtl/sim_ctrl_fifo.sv
// sim_ctrl_fifo: synchronous 8-bit x DEPTH FIFO for console characters.
//   clk, rst_b      - clock, asynchronous active-low reset (clears contents)
//   push, push_data - write request and byte
//   pop             - read request (ignored when empty)
//   full, empty     - occupancy flags
//   head            - byte at the head of the FIFO
// A push while full is accepted only if a pop frees an entry in the same cycle.
`timescale 1ns/1ps
module sim_ctrl_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sim_ctrl_mon.sv
// sim_ctrl_mon: simulation-control monitor. Snoops AHB-Lite writes to a mailbox
// address and decodes pass / fail / console-character events; also enforces an
// idle-retire watchdog and a run-cycle budget.
//   clk, rst_b          - clock, asynchronous active-low reset
//   ahb_*               - snooped AHB-Lite signals
//   retire              - per-hart retire strobes
//   char_valid/data/ready - console FIFO drain port (pop on valid && ready)
//   done, pass, fail    - sticky termination status
//   fail_code           - failure cause (FC_SW / FC_WDOG / FC_BUDGET)
//   cycle_cnt           - saturating count of cycles spent running
//   drop_cnt            - saturating count of bytes lost to a full FIFO
`timescale 1ns/1ps
module sim_ctrl_mon
  import sim_ctrl_pkg::*;
#(
  parameter int unsigned        NUM_HARTS   = 1,
  parameter int unsigned        ADDR_W      = 32,
  parameter logic [ADDR_W-1:0]  MBOX_ADDR   = 32'h6000_fff8,
  parameter int unsigned        WDOG_CYCLES = 5000,
  parameter logic [31:0]        MAX_CYCLES  = 32'hFFFF_FFFF,
  parameter int unsigned        FIFO_DEPTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic [1:0]           ahb_htrans,
  input  logic [ADDR_W-1:0]    ahb_haddr,
  input  logic                 ahb_hwrite,
  input  logic                 ahb_hready,
  input  logic [31:0]          ahb_hwdata,
  input  logic [NUM_HARTS-1:0] retire,
  input  logic                 char_ready,
  output logic                 char_valid,
  output logic [7:0]           char_data,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic [1:0]           fail_code,
  output logic [31:0]          cycle_cnt,
  output logic [7:0]           drop_cnt
);

  localparam int unsigned IDLE_W = $clog2(WDOG_CYCLES + 1);

  state_e            state_q, state_d;
  logic [1:0]        fail_code_q, fail_code_d;
  logic              pend_q, pend_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [31:0]       cycle_cnt_q, cycle_cnt_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic              pass_q, fail_q, done_q;

  logic in_run, addr_accept, data_done;
  logic sw_pass, sw_fail, char_push, wdog_hit, budget_hit;
  logic fifo_full, fifo_empty, fifo_pop;

  // htrans[1] covers both NONSEQ and SEQ.
  assign addr_accept = ahb_hready && ahb_htrans[1] && ahb_hwrite && (ahb_haddr == MBOX_ADDR);
  assign data_done   = pend_q && ahb_hready;
  // On a ready cycle the old data phase ends and a new address phase may start.
  assign pend_d      = ahb_hready ? addr_accept : pend_q;

  assign in_run     = (state_q == StRun);
  assign sw_pass    = in_run && data_done && is_pass_word(ahb_hwdata);
  assign sw_fail    = in_run && data_done && is_fail_word(ahb_hwdata);
  assign char_push  = in_run && data_done && !is_pass_word(ahb_hwdata)
                      && !is_fail_word(ahb_hwdata);
  assign wdog_hit   = in_run && (idle_q == IDLE_W'(WDOG_CYCLES));
  // Fire on the edge where the count reaches the budget so the reported
  // cycle_cnt equals MAX_CYCLES.
  assign budget_hit = in_run && (MAX_CYCLES != 32'd0) && (cycle_cnt_q == MAX_CYCLES - 32'd1);

  assign char_valid = !fifo_empty;
  assign fifo_pop   = char_valid && char_ready;

  always_comb begin
    state_d     = state_q;
    fail_code_d = fail_code_q;
    case (state_q)
      StRun: begin
        if (sw_pass) begin
          state_d = StPass;
        end else if (sw_fail) begin
          state_d     = StFail;
          fail_code_d = FC_SW;
        end else if (wdog_hit) begin
          state_d     = StFail;
          fail_code_d = FC_WDOG;
        end else if (budget_hit) begin
          state_d     = StFail;
          fail_code_d = FC_BUDGET;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    idle_d      = idle_q;
    cycle_cnt_d = cycle_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (in_run) begin
      if (|retire) idle_d = '0;
      else if (idle_q != IDLE_W'(WDOG_CYCLES)) idle_d = idle_q + IDLE_W'(1);
      if (cycle_cnt_q != 32'hFFFF_FFFF) cycle_cnt_d = cycle_cnt_q + 32'd1;
    end
    if (char_push && fifo_full && !fifo_pop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= StRun;
      fail_code_q <= FC_NONE;
      pend_q      <= 1'b0;
      idle_q      <= '0;
      cycle_cnt_q <= '0;
      drop_cnt_q  <= '0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fail_code_q <= fail_code_d;
      pend_q      <= pend_d;
      idle_q      <= idle_d;
      cycle_cnt_q <= cycle_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      pass_q      <= (state_d == StPass);
      fail_q      <= (state_d == StFail);
      done_q      <= (state_d != StRun);
    end
  end

  sim_ctrl_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_b     (rst_b),
    .push      (char_push),
    .push_data (ahb_hwdata[7:0]),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (char_data)
  );

  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign fail_code = fail_code_q;
  assign cycle_cnt = cycle_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_sim_ctrl_mon.sv
`timescale 1ns/1ps
module tb_sim_ctrl_mon;
  import sim_ctrl_pkg::*;

  localparam logic [31:0] MBOX = 32'h6000_fff8;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic        hwrite, hready;
  logic [31:0] hwdata;
  logic [1:0]  retire;
  logic        char_ready;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        done, pass, fail;
  logic [1:0]  fail_code;
  logic [31:0] cycle_cnt;
  logic [7:0]  drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sim_ctrl_mon #(
    .NUM_HARTS   (2),
    .ADDR_W      (32),
    .MBOX_ADDR   (MBOX),
    .WDOG_CYCLES (8),
    .MAX_CYCLES  (32'd100),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .ahb_htrans (htrans),
    .ahb_haddr  (haddr),
    .ahb_hwrite (hwrite),
    .ahb_hready (hready),
    .ahb_hwdata (hwdata),
    .retire     (retire),
    .char_ready (char_ready),
    .char_valid (char_valid),
    .char_data  (char_data),
    .done       (done),
    .pass       (pass),
    .fail       (fail),
    .fail_code  (fail_code),
    .cycle_cnt  (cycle_cnt),
    .drop_cnt   (drop_cnt)
  );

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    htrans = 2'b00; haddr = '0; hwrite = 1'b0; hready = 1'b1; hwdata = '0;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    idle_bus();
    retire = 2'b11;
    char_ready = 1'b0;
    tick();
    tick();
    rst_b = 1'b1;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w);
    htrans = 2'b10; haddr = a; hwrite = w; hready = 1'b1;
    tick();
    htrans = 2'b00; haddr = '0; hwrite = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({char_valid, char_data, done, pass, fail, fail_code, drop_cnt, cycle_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: valid=%b data=%h done=%b pass=%b fail=%b fc=%0d drop=%0d cyc=%0d, required all 0",
               char_valid, char_data, done, pass, fail, fail_code, drop_cnt, cycle_cnt);
    end
  endtask

  task automatic test_console();
    do_reset();
    char_ready = 1'b1;
    htrans = 2'b10; haddr = MBOX; hwrite = 1'b1;
    tick();
    hwdata = 32'h48;
    tick();
    n_cmp++;
    if ({char_valid, char_data} !== {1'b1, 8'h48}) begin
      n_err++;
      $display("FAIL console_H: valid=%b data=%h, required 1 48", char_valid, char_data);
    end
    hwdata = 32'h69;
    tick();
    n_cmp++;
    if ({char_valid, char_data, pass} !== {1'b1, 8'h69, 1'b0}) begin
      n_err++;
      $display("FAIL console_i: valid=%b data=%h pass=%b, required 1 69 0", char_valid, char_data, pass);
    end
    htrans = 2'b00; hwrite = 1'b0; hwdata = PASS_W0;
    tick();
    n_cmp++;
    if ({pass, done, fail, char_valid, drop_cnt} !== {1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin
      n_err++;
      $display("FAIL console_pass: pass=%b done=%b fail=%b valid=%b drop=%0d, required 1 1 0 0 0",
               pass, done, fail, char_valid, drop_cnt);
    end
    idle_bus();
  endtask

  task automatic test_sw_fail_wait();
    do_reset();
    addr_phase(MBOX, 1'b1);
    hwdata = FAIL_W1;
    hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (fail !== 1'b0) begin
        n_err++;
        $display("FAIL swfail_wait%0d: fail=%b, required 0", i, fail);
      end
    end
    hready = 1'b1;
    tick();
    n_cmp++;
    if ({fail, fail_code, done, pass, char_valid} !== {1'b1, FC_SW, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL swfail_done: fail=%b fc=%0d done=%b pass=%b valid=%b, required 1 1 1 0 0",
               fail, fail_code, done, pass, char_valid);
    end
    idle_bus();
  endtask

  task automatic test_decode_filter();
    do_reset();
    char_ready = 1'b0;
    addr_phase(MBOX + 32'd4, 1'b1);         // wrong address
    hwdata = PASS_W0;
    tick();
    addr_phase(MBOX, 1'b0);                 // read, not write
    hwdata = PASS_W0;
    tick();
    htrans = 2'b10; haddr = MBOX; hwrite = 1'b1; hready = 1'b0;  // not accepted
    tick();
    htrans = 2'b00; hwrite = 1'b0; hready = 1'b1; hwdata = PASS_W0;
    tick();
    n_cmp++;
    if ({pass, fail, char_valid} !== 3'b000) begin
      n_err++;
      $display("FAIL filter: pass=%b fail=%b valid=%b, required 0 0 0", pass, fail, char_valid);
    end
    addr_phase(MBOX, 1'b1);
    hwdata = FAIL_W0;
    tick();
    addr_phase(MBOX, 1'b1);                 // after termination: ignored
    hwdata = PASS_W1;
    tick();
    addr_phase(MBOX, 1'b1);
    hwdata = 32'h5A;
    tick();
    n_cmp++;
    if ({fail, fail_code, pass, char_valid} !== {1'b1, FC_SW, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL sticky_fail: fail=%b fc=%0d pass=%b valid=%b, required 1 1 0 0",
               fail, fail_code, pass, char_valid);
    end
    idle_bus();
  endtask

  task automatic test_watchdog();
    int early;
    do_reset();
    retire = 2'b01;
    tick();
    retire = 2'b00;
    for (int i = 1; i <= 8; i++) begin
      tick();
      n_cmp++;
      if (fail !== 1'b0) begin
        n_err++;
        $display("FAIL wdog_early k+%0d: fail=%b, required 0", i, fail);
      end
    end
    tick();
    n_cmp++;
    if ({fail, fail_code, done} !== {1'b1, FC_WDOG, 1'b1}) begin
      n_err++;
      $display("FAIL wdog_fire: fail=%b fc=%0d done=%b, required 1 2 1", fail, fail_code, done);
    end
    // A retire at idle count 7 restarts the window.
    do_reset();
    retire = 2'b01;
    tick();
    retire = 2'b00;
    repeat (7) tick();
    retire = 2'b10;
    tick();
    retire = 2'b00;
    early = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (fail !== 1'b0) early++;
    end
    n_cmp++;
    if (early != 0) begin
      n_err++;
      $display("FAIL wdog_rearm: early fail cycles=%0d, required 0", early);
    end
    tick();
    n_cmp++;
    if ({fail, fail_code} !== {1'b1, FC_WDOG}) begin
      n_err++;
      $display("FAIL wdog_rearm_fire: fail=%b fc=%0d, required 1 2", fail, fail_code);
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0] exp_q [4];
    exp_q = '{8'h31, 8'h32, 8'h33, 8'h36};
    do_reset();
    char_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      addr_phase(MBOX, 1'b1);
      hwdata = 32'h30 + i;
      tick();
    end
    n_cmp++;
    if ({drop_cnt, char_valid, char_data} !== {8'd2, 1'b1, 8'h30}) begin
      n_err++;
      $display("FAIL fifo_fill: drop=%0d valid=%b data=%h, required 2 1 30",
               drop_cnt, char_valid, char_data);
    end
    // Push into a full FIFO while popping: accepted, no drop.
    addr_phase(MBOX, 1'b1);
    hwdata = 32'h36;
    char_ready = 1'b1;
    tick();
    n_cmp++;
    if ({drop_cnt, char_data} !== {8'd2, 8'h31}) begin
      n_err++;
      $display("FAIL fifo_pushpop: drop=%0d data=%h, required 2 31", drop_cnt, char_data);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({char_valid, char_data} !== {1'b1, exp_q[i]}) begin
        n_err++;
        $display("FAIL fifo_drain%0d: valid=%b data=%h, required 1 %h", i, char_valid, char_data, exp_q[i]);
      end
      tick();
    end
    n_cmp++;
    if (char_valid !== 1'b0) begin
      n_err++;
      $display("FAIL fifo_empty: valid=%b, required 0", char_valid);
    end
    idle_bus();
  endtask

  task automatic test_priority();
    do_reset();
    retire = 2'b01;
    tick();                       // edge k: cycle_cnt=1
    retire = 2'b00;
    repeat (7) tick();
    addr_phase(MBOX, 1'b1);
    hwdata = PASS_W1;
    tick();                       // edge k+9: pass and watchdog coincide
    n_cmp++;
    if ({pass, fail, fail_code} !== {1'b1, 1'b0, FC_NONE}) begin
      n_err++;
      $display("FAIL prio_pass: pass=%b fail=%b fc=%0d, required 1 0 0", pass, fail, fail_code);
    end
    idle_bus();
    retire = 2'b00;
    repeat (3) tick();
    n_cmp++;
    if ({pass, fail, cycle_cnt} !== {1'b1, 1'b0, 32'd10}) begin
      n_err++;
      $display("FAIL prio_hold: pass=%b fail=%b cyc=%0d, required 1 0 10", pass, fail, cycle_cnt);
    end
  endtask

  task automatic test_budget();
    do_reset();
    repeat (99) tick();
    n_cmp++;
    if ({fail, cycle_cnt} !== {1'b0, 32'd99}) begin
      n_err++;
      $display("FAIL budget_pre: fail=%b cyc=%0d, required 0 99", fail, cycle_cnt);
    end
    tick();
    n_cmp++;
    if ({fail, fail_code, cycle_cnt} !== {1'b1, FC_BUDGET, 32'd100}) begin
      n_err++;
      $display("FAIL budget_fire: fail=%b fc=%0d cyc=%0d, required 1 3 100", fail, fail_code, cycle_cnt);
    end
    repeat (5) tick();
    n_cmp++;
    if (cycle_cnt !== 32'd100) begin
      n_err++;
      $display("FAIL budget_freeze: cyc=%0d, required 100", cycle_cnt);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    char_ready = 1'b0;
    addr_phase(MBOX, 1'b1);
    hwdata = 32'h41;
    tick();
    htrans = 2'b10; haddr = MBOX; hwrite = 1'b1;
    tick();                       // pend set, FIFO holds 0x41
    htrans = 2'b00; hwrite = 1'b0; hwdata = PASS_W0;
    rst_b = 1'b0;
    #1;
    n_cmp++;
    if ({char_valid, char_data, done, pass, fail, fail_code, drop_cnt, cycle_cnt} !== '0) begin
      n_err++;
      $display("FAIL midreset_outputs: valid=%b data=%h done=%b pass=%b cyc=%0d, required all 0",
               char_valid, char_data, done, pass, cycle_cnt);
    end
    tick();
    rst_b = 1'b1;
    tick();                       // hready high with the old pend gone
    n_cmp++;
    if ({pass, char_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL midreset_pend: pass=%b valid=%b, required 0 0", pass, char_valid);
    end
    addr_phase(MBOX, 1'b1);
    hwdata = PASS_W0;
    tick();
    n_cmp++;
    if ({pass, done, fail} !== 3'b110) begin
      n_err++;
      $display("FAIL midreset_after: pass=%b done=%b fail=%b, required 1 1 0", pass, done, fail);
    end
    idle_bus();
  endtask

  initial begin
    rst_b = 1'b0;
    idle_bus();
    retire = 2'b11;
    char_ready = 1'b0;
    test_reset();
    test_console();
    test_sw_fail_wait();
    test_decode_filter();
    test_watchdog();
    test_fifo_full();
    test_priority();
    test_budget();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
